mul_add_seq: RTL and testbench
==============================

MUL_ADD_SEQ -- requirements
Module: mul_add_seq

Interface
REQ-001 SHALL have parameter WA, default 8, width of factor_a (multiplier, consumed one bit per step).
REQ-002 SHALL have parameter WB, default 8, width of factor_b and addend.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin an operation; sampled on clk.
REQ-006 SHALL have port factor_a  input  WA  multiplier; sampled only when start is accepted.
REQ-007 SHALL have port factor_b  input  WB  multiplicand; sampled only when start is accepted.
REQ-008 SHALL have port addend  input  WB  value added to the product; sampled only when start is accepted.
REQ-009 SHALL have port result  output  WA+WB  factor_a*factor_b+addend, unsigned.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking that result is valid.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-013 SHALL accept start only when busy=0 (state IDLE or DONE): latch operands, set accumulator=zero-extended addend, step index=0, go to RUN.
REQ-014 SHALL ignore start while busy=1; latched operands and progress are unaffected.
REQ-015 SHALL in each RUN cycle add (factor_b << step) to the accumulator when factor_a[step]=1, then increment step.
REQ-016 SHALL leave RUN after the final step and enter DONE for exactly one cycle, then IDLE unless start is accepted in that DONE cycle.
REQ-017 SHALL drive busy=1 exactly in RUN, and done=1 exactly in DONE.
REQ-018 SHALL, in default build, assert done exactly WA+1 clock edges after the edge that accepts start.
REQ-019 SHALL update result only on entry to DONE and hold it until the next DONE; result is never altered mid-operation.
REQ-020 SHALL compute without overflow: the maximum (2^WA-1)(2^WB-1)+(2^WB-1) fits in WA+WB bits; no truncation is permitted.
REQ-021 SHALL, for start accepted in the DONE cycle, pulse done for the previous operation in that cycle and begin the new operation with no idle cycle.
REQ-022 SHALL treat factor_a=0 or factor_b=0 as ordinary operations with result=addend.

Reset
REQ-023 SHALL on rst_n=0 immediately set state=IDLE, result=0, busy=0, done=0, accumulator/step/latched operands=0, independent of clk.
REQ-024 SHALL on reset during RUN abandon the operation; no done pulse follows and result reads 0.
REQ-025 SHALL accept start on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when macro MUL_ADD_SEQ_EARLY_EXIT_EN is defined, leave RUN once all remaining unprocessed bits of factor_a are zero, so RUN length = (index of highest set bit of factor_a)+1, and 0 cycles if factor_a=0 (straight IDLE->DONE, done 1 edge after start).
REQ-027 SHALL, without MUL_ADD_SEQ_EARLY_EXIT_EN, always run exactly WA RUN cycles regardless of operand values; result values are identical in both builds.

Verification (WA=WB=8)
REQ-028 SHALL cover: a=3, b=8, addend=0 -> done pulse 9 edges after start, result=24, busy high 8 cycles.
REQ-029 SHALL cover: a=255, b=255, addend=255 -> result=65280, no overflow.
REQ-030 SHALL cover: start pulsed again at cycle 4 of an operation with new operands a=1, b=1 -> ignored; first result unchanged, single done pulse.
REQ-031 SHALL cover: rst_n low at cycle 5 of a=11, b=8 -> busy/done/result=0 immediately, no done follows; next start a=11, b=8, addend=3 -> result=91.
REQ-032 SHALL cover: start held high continuously with a=2, b=5, addend=1 -> back-to-back operations, done every 9 cycles, result=11 each time.
REQ-033 SHALL cover: with MUL_ADD_SEQ_EARLY_EXIT_EN, a=1, b=5, addend=0 -> done 2 edges after start, result=5; a=0 -> done 1 edge after start, result=addend; without macro both take 9 edges.

Source files
------------

// File: rtl/mul_add_seq.sv
// Sequential shift-and-add multiply-accumulate: result = factor_a * factor_b + addend.
// Optional MUL_ADD_SEQ_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier bits are zero.
module mul_add_seq #(
    parameter int WA = 8,
    parameter int WB = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WA-1:0]      factor_a,
    input  logic [WB-1:0]      factor_b,
    input  logic [WB-1:0]      addend,
    output logic [WA+WB-1:0]   result,
    output logic               busy,
    output logic               done
);

    localparam int W  = WA + WB;
    localparam int SW = (WA > 1) ? $clog2(WA) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [WA-1:0] a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic [W-1:0]  acc_reg, acc_next;
    logic [W-1:0]  result_reg, result_next;
    logic [SW-1:0] step_reg, step_next;
    logic [W-1:0]  acc_sum;
    logic          last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            step_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            step_reg   <= step_next;
        end
    end

    // a_reg shifts right and b_reg shifts left, so bit 0 of a_reg is always the current step's bit.
    always_comb begin
        acc_sum = a_reg[0] ? (acc_reg + b_reg) : acc_reg;
    end

    always_comb begin
        last_step = (step_reg == SW'(WA - 1));
`ifdef MUL_ADD_SEQ_EARLY_EXIT_EN
        if ((a_reg >> 1) == '0) begin
            last_step = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        step_next   = step_reg;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    a_next     = factor_a;
                    b_next     = W'(factor_b);
                    acc_next   = W'(addend);
                    step_next  = '0;
                    state_next = RUN;
`ifdef MUL_ADD_SEQ_EARLY_EXIT_EN
                    if (factor_a == '0) begin
                        state_next  = DONE;
                        result_next = W'(addend);
                    end
`endif
                end
            end
            RUN: begin
                acc_next  = acc_sum;
                a_next    = a_reg >> 1;
                b_next    = b_reg << 1;
                step_next = step_reg + 1'b1;
                if (last_step) begin
                    state_next  = DONE;
                    result_next = acc_sum;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result = result_reg;
    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);

endmodule

// File: tb/tb_mul_add_seq.sv
// Scoreboard bench for mul_add_seq (WA=WB=8); latency is counted in rising edges
// including the edge that accepts start, and expectations follow MUL_ADD_SEQ_EARLY_EXIT_EN.
module tb_mul_add_seq;

    localparam int WA = 8;
    localparam int WB = 8;
`ifdef MUL_ADD_SEQ_EARLY_EXIT_EN
    localparam bit EE       = 1'b1;
    localparam int RST_WAIT = 3;
`else
    localparam bit EE       = 1'b0;
    localparam int RST_WAIT = 5;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [WA-1:0]      factor_a = '0;
    logic [WB-1:0]      factor_b = '0;
    logic [WB-1:0]      addend = '0;
    logic [WA+WB-1:0]   result;
    logic               busy;
    logic               done;

    mul_add_seq #(.WA(WA), .WB(WB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .factor_a (factor_a),
        .factor_b (factor_b),
        .addend   (addend),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int lat_sel(input int lat_def, input int lat_ee);
        return EE ? lat_ee : lat_def;
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 want=0 result=%0d (t=%0t)", result, $time);
            end else begin
                mon_e = q.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                check("busy_cycles", 32'(busy_cnt), 32'(mon_e.lat - 1));
                $display("op done: result=%0d latency=%0d busy=%0d", result, cyc - mon_e.acc + 1, busy_cnt);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ad,
                          input logic [15:0] res, input int lat_def, input int lat_ee);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        factor_a = a;
        factor_b = b;
        addend = ad;
        @(posedge clk);
        #1;
        e.res = res;
        e.lat = lat_sel(lat_def, lat_ee);
        e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        factor_a = 8'($urandom);
        factor_b = 8'($urandom);
        addend = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d pending want=0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c0;
        int   p;
        repeat (3) @(negedge clk);
        check("reset_result", 32'(result), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // a=3 b=8: 24; first start right after reset release
        run_op(8'd3, 8'd8, 8'd0, 16'd24, 9, 3);
        drain();
        // maximum operands: no overflow
        run_op(8'd255, 8'd255, 8'd255, 16'd65280, 9, 9);
        drain();
        run_op(8'd1, 8'd5, 8'd0, 16'd5, 9, 2);
        drain();
        run_op(8'd0, 8'd77, 8'd9, 16'd9, 9, 1);
        drain();
        run_op(8'hAA, 8'd0, 8'd200, 16'd200, 9, 9);
        drain();

        // start while busy is ignored
        run_op(8'd200, 8'd9, 8'd2, 16'd1802, 9, 9);
        repeat (3) @(negedge clk);
        start = 1'b1;
        factor_a = 8'd1;
        factor_b = 8'd1;
        addend = 8'd0;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("hold_result", 32'(result), 32'd1802);
        check("idle_busy", 32'(busy), 32'd0);

        // reset mid-RUN abandons the operation
        run_op(8'd11, 8'd8, 8'd0, 16'd88, 9, 5);
        repeat (RST_WAIT - 2) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op(8'd11, 8'd8, 8'd3, 16'd91, 9, 5);
        drain();

        // start held high: back-to-back operations
        p = lat_sel(9, 3);
        @(negedge clk);
        start = 1'b1;
        factor_a = 8'd2;
        factor_b = 8'd5;
        addend = 8'd1;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.res = 16'd11;
            e.lat = p;
            e.acc = c0 + k * p;
            q.push_back(e);
        end
        repeat (2 * p) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("final_result", 32'(result), 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
